filter_seq_ctrl: RTL

Sequencer and configuration controller for the single-channel IIR ADC smoothing filter. It holds the filter coefficient, accepts runtime coefficient and settle-time updates over a valid/ready handshake, and flushes the filter state on every change. It then blanks the filter output until the IIR has settled and re-qualifies it with a valid strobe. The block sits between the control register bank and the filter instance on the ADC path.

---
 rtl/filter_ctrl_pkg.sv | 14 +
 rtl/ctrl_down_counter.sv | 34 +++
 rtl/filter_seq_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/filter_ctrl_pkg.sv
// Shared types and reset defaults for the IIR smoothing-filter sequencer.
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } ctrl_state_t;

  localparam int unsigned COEF_DEFAULT_C   = 1079;
  localparam int unsigned SETTLE_DEFAULT_C = 64;
  localparam int unsigned FLUSH_CYCLES_C   = 4;

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable down counter that parks at zero; shared by the FLUSH and SETTLE phases.
module ctrl_down_counter #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/filter_seq_ctrl.sv
// Coefficient/settle configuration and flush-settle-run sequencing for the ADC IIR filter.
//   state  | meaning
//   FLUSH  | filt_clear held high, filter state being wiped
//   SETTLE | filter running from clean state, output still blanked
//   RUN    | output qualified, configuration requests accepted
module filter_seq_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int unsigned ADC_WIDTH      = 14,
  parameter int unsigned COEF_WIDTH     = 16,
  parameter int unsigned COEF_DEFAULT   = COEF_DEFAULT_C,
  parameter int unsigned SETTLE_WIDTH   = 16,
  parameter int unsigned SETTLE_DEFAULT = SETTLE_DEFAULT_C,
  parameter int unsigned FLUSH_CYCLES   = FLUSH_CYCLES_C
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [COEF_WIDTH-1:0]       cfg_coef,
  input  logic [SETTLE_WIDTH-1:0]     cfg_settle,
  output logic                        cfg_err,
  output logic [COEF_WIDTH-1:0]       filt_coef,
  output logic                        filt_clear,
  input  logic signed [ADC_WIDTH-1:0] filt_in,
  output logic signed [ADC_WIDTH-1:0] out_data,
  output logic                        out_valid,
  output logic                        busy
);

  // The counter holds "cycles remaining minus one", so the phase ends on the zero flag.
  localparam logic [SETTLE_WIDTH-1:0] FLUSH_LOAD = SETTLE_WIDTH'(FLUSH_CYCLES - 1);

  ctrl_state_t             state_q, state_d;
  logic [COEF_WIDTH-1:0]   coef_q, coef_d;
  logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
  logic                    cnt_load;
  logic [SETTLE_WIDTH-1:0] cnt_val;
  logic                    cnt_zero;
  logic                    cfg_err_d;

  logic                        filt_clear_q, cfg_ready_q, cfg_err_q, out_valid_q, busy_q;
  logic signed [ADC_WIDTH-1:0] out_data_q;

  ctrl_down_counter #(
    .WIDTH     (SETTLE_WIDTH),
    .RESET_VAL (FLUSH_LOAD)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    coef_d    = coef_q;
    settle_d  = settle_q;
    cnt_load  = 1'b0;
    cnt_val   = FLUSH_LOAD;
    cfg_err_d = 1'b0;
    case (state_q)
      FLUSH: begin
        if (cnt_zero) begin
          if (settle_q == '0) begin
            state_d = RUN;
          end else begin
            state_d  = SETTLE;
            cnt_load = 1'b1;
            cnt_val  = settle_q - SETTLE_WIDTH'(1);
          end
        end
      end
      SETTLE: begin
        if (cnt_zero) state_d = RUN;
      end
      RUN: begin
        if (cfg_valid && cfg_ready_q) begin
          // A zero coefficient would freeze the filter, so it is refused without side effects.
          if (cfg_coef != '0) begin
            coef_d   = cfg_coef;
            settle_d = cfg_settle;
            state_d  = FLUSH;
            cnt_load = 1'b1;
            cnt_val  = FLUSH_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = FLUSH;
        cnt_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FLUSH;
      coef_q       <= COEF_WIDTH'(COEF_DEFAULT);
      settle_q     <= SETTLE_WIDTH'(SETTLE_DEFAULT);
      filt_clear_q <= 1'b1;
      cfg_ready_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      coef_q       <= coef_d;
      settle_q     <= settle_d;
      filt_clear_q <= (state_d == FLUSH);
      cfg_ready_q  <= (state_d == RUN);
      cfg_err_q    <= cfg_err_d;
      out_valid_q  <= (state_d == RUN);
      out_data_q   <= (state_d == RUN) ? filt_in : '0;
      busy_q       <= (state_d != RUN);
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;
  assign filt_coef  = coef_q;
  assign filt_clear = filt_clear_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;

endmodule
